lpm_concat_packer: RTL



---
 rtl/lpm_concat_pkg.sv | 21 ++
 rtl/lpm_concat_packer_if.sv | 34 +++
 rtl/lpm_concat_acc.sv | 62 ++++++
 rtl/lpm_concat_packer.sv | 77 +++++++
 4 files changed

// File: rtl/lpm_concat_pkg.sv
// Shared widths and state encoding for the concat packer and its accumulator.
package lpm_concat_pkg;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  typedef enum logic {
    StEmpty = ST_EMPTY,
    StFull  = ST_FULL
  } state_e;

  function automatic int unsigned out_w(int unsigned in_w, int unsigned ratio,
                                        int unsigned tag_w);
    return tag_w + ratio * in_w;
  endfunction

  function automatic int unsigned cnt_w(int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/lpm_concat_packer_if.sv
// Input/output stream handshake bundle; slave is the packer, master is the driver side.
interface lpm_concat_packer_if
  import lpm_concat_pkg::*;
#(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned RATIO = 4,
  parameter int unsigned TAG_W = 2
) ();

  localparam int unsigned OutW = out_w(IN_W, RATIO, TAG_W);
  localparam int unsigned CntW = cnt_w(RATIO);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OutW-1:0]  out_data;
  logic [CntW-1:0]  out_count;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );

endinterface

// File: rtl/lpm_concat_acc.sv
// Slot-indexed word accumulator with word counter and tag capture; presents the
// pack that would complete with the currently offered word.
module lpm_concat_acc
  import lpm_concat_pkg::*;
#(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned RATIO = 4,
  parameter int unsigned TAG_W = 2,
  localparam int unsigned CntW = cnt_w(RATIO),
  localparam int unsigned OutW = out_w(IN_W, RATIO, TAG_W)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             accept,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_tag,
  output logic [CntW-1:0]  cnt,
  output logic             done,
  output logic [OutW-1:0]  pack,
  output logic [CntW-1:0]  pack_count
);

  localparam int unsigned    SlotsW = RATIO * IN_W;
  localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);

  logic [SlotsW-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q;
  logic [TAG_W-1:0]  tag_q, tag_d;

  always_comb begin
    acc_d = acc_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (cnt_q == CntW'(k)) acc_d[(RATIO-1-k)*IN_W +: IN_W] = in_data;
    end
    // First word of a pack supplies the tag directly, so single-word packs see it too.
    tag_d = (cnt_q == '0) ? in_tag : tag_q;
    done  = accept && ((cnt_q == CntMax) || in_last);
  end

  assign pack       = {tag_d, acc_d};
  assign pack_count = cnt_q + CntW'(1);
  assign cnt        = cnt_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc_q <= '0;
      cnt_q <= '0;
      tag_q <= '0;
    end else if (accept) begin
      if (done) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CntW'(1);
        tag_q <= tag_d;
      end
    end
  end

endmodule

// File: rtl/lpm_concat_packer.sv
// Packs RATIO narrow words plus a tag into one wide word; holds the output register,
// the EMPTY/FULL control state and the input-side ready.
module lpm_concat_packer
  import lpm_concat_pkg::*;
#(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned RATIO = 4,
  parameter int unsigned TAG_W = 2
) (
  input logic                clock,
  input logic                resetn,
  lpm_concat_packer_if.slave bus
);

  localparam int unsigned    CntW   = cnt_w(RATIO);
  localparam int unsigned    OutW   = out_w(IN_W, RATIO, TAG_W);
  localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);

  state_e          state_q;
  logic [OutW-1:0] out_data_q;
  logic [CntW-1:0] out_count_q;
  logic            out_last_q;

  logic            accept;
  logic            done;
  logic [CntW-1:0] cnt;
  logic [OutW-1:0] pack;
  logic [CntW-1:0] pack_count;

  // A completing word may only enter when the output slot is free or freeing.
  assign bus.in_ready = (state_q == StEmpty) || bus.out_ready ||
                        ((cnt != CntMax) && !bus.in_last);
  assign accept       = bus.in_valid && bus.in_ready;

  lpm_concat_acc #(
    .IN_W  (IN_W),
    .RATIO (RATIO),
    .TAG_W (TAG_W)
  ) u_acc (
    .clock      (clock),
    .resetn     (resetn),
    .accept     (accept),
    .in_data    (bus.in_data),
    .in_last    (bus.in_last),
    .in_tag     (bus.in_tag),
    .cnt        (cnt),
    .done       (done),
    .pack       (pack),
    .pack_count (pack_count)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StEmpty;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (done) begin
        out_data_q  <= pack;
        out_count_q <= pack_count;
        out_last_q  <= bus.in_last;
      end
      unique case (state_q)
        StEmpty: if (done) state_q <= StFull;
        StFull:  if (!done && bus.out_ready) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign bus.out_valid = (state_q == StFull);
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_last  = out_last_q;

endmodule
